snn_input_loader: RTL
=====================

// Module: snn_input_loader
// PURPOSE
//  Upstream feeder for the SNN core. Collects a 784-pixel binary image arriving as bytes from the UART receiver.
//  Stores it in an internal 784x1 bit buffer and pulses start to the core.
//  Serves the core's q_input reads during inference, then captures the core's digit/done result for downstream consumers.
//  Sits between uart_rx and the SNN core.
// PARAMETERS
//  NUM_PIXELS      784      image size in bits; must be a multiple of 8
//  TIMEOUT_CYCLES  500000   inter-byte idle limit; used only with SNN_LOAD_TIMEOUT_EN
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  rst             in   1   asynchronous, active-high reset
//  rx_rdy          in   1   one-cycle strobe: rx_data valid
//  rx_data         in   8   received byte; bit i = pixel 8*k+i of byte k (LSB first)
//  addr_input_unit in   10  pixel read address from core
//  q_input         out  1   pixel at addr_input_unit, registered (1-cycle read latency)
//  start           out  1   one-cycle pulse to core: image complete
//  core_done       in   1   one-cycle pulse from core: inference finished
//  core_digit      in   4   core result, valid when core_done=1
//  busy            out  1   high from start pulse until core_done accepted
//  result_vld      out  1   one-cycle pulse: result_digit updated
//  result_digit    out  4   last classified digit, held until next core_done
//  ovf_err         out  1   sticky: byte received while busy; cleared by rst only
//  timeout_err     out  1   one-cycle pulse: partial image discarded on timeout
// BEHAVIOUR
//  - Reset values: q_input=0, start=0, busy=0, result_vld=0, result_digit=0, ovf_err=0, timeout_err=0.
//    Reset also clears byte_cnt and puts the FSM in LOAD. Buffer contents are not reset.
//  - Reset mid-operation: the partial image is discarded and the FSM returns to LOAD; a core_done arriving later is ignored.
//  - byte_cnt is 7 bits, range 0..NUM_PIXELS/8-1 (0..97).
//  - FSM LOAD:
//    - rx_rdy writes rx_data into buffer bits [8*byte_cnt+7 : 8*byte_cnt] at that edge.
//    - If byte_cnt==97, byte_cnt wraps to 0 and the FSM moves to START; otherwise byte_cnt increments.
//  - FSM START: start=1 and busy=1 for exactly one cycle; next state WAIT_DONE.
//    - The start pulse occurs in the cycle after the edge that wrote the 98th byte.
//  - FSM WAIT_DONE: busy=1.
//    - rx_rdy is dropped (no write, byte_cnt unchanged) and sets ovf_err.
//    - core_done latches core_digit into result_digit, pulses result_vld in the following cycle, and moves the FSM to LOAD.
//  - Simultaneous rx_rdy and core_done in WAIT_DONE: the byte is dropped, ovf_err is set, and the done is processed normally.
//  - core_done in LOAD or START is ignored; no result_vld.
//  - Buffer read:
//    - q_input <= buf[addr_input_unit] every cycle, in every state.
//    - addr_input_unit >= NUM_PIXELS gives q_input=0.
//  - No read/write hazard: writes only in LOAD, the core reads only while busy.
//  - Buffer holds its contents after inference; the next image overwrites it byte by byte.
// CONFIGURATION
//  SNN_LOAD_TIMEOUT_EN defined:
//    - A 19-bit idle counter runs in LOAD while byte_cnt!=0 and clears on each accepted byte.
//    - On reaching TIMEOUT_CYCLES-1: byte_cnt<=0, timeout_err pulses one cycle, and the counter clears.
//    - The counter is held at 0 in START/WAIT_DONE and when byte_cnt==0.
//    - rx_rdy in the same cycle as the timeout: the byte is taken as byte 0 of a new image (byte_cnt<=1).
//  SNN_LOAD_TIMEOUT_EN undefined:
//    - No counter; timeout_err is tied to 0; a partial image waits indefinitely.
// TESTING
//  - Reset then 98 bytes 0xA5 -> start pulses once, one cycle after the 98th rx_rdy edge.
//    With addr 0..7 the core sees q_input 1,0,1,0,0,1,0,1 one cycle after each address.
//  - Full image loaded, core_done with core_digit=7 -> result_vld one cycle later, result_digit=7, busy=0.
//    FSM returns to LOAD with byte_cnt=0.
//  - rx_rdy in WAIT_DONE with 0xFF -> ovf_err=1 and stays 1; buffer unchanged (pixel 0 still matches the prior image).
//    rx_rdy together with core_done -> byte dropped, result captured.
//  - 50 bytes then rst pulse, then 98 bytes -> exactly one start, after the 98th post-reset byte.
//    A core_done pulse in LOAD is ignored.
//  - addr_input_unit=784 and 1023 -> q_input=0; addr=783 returns bit 7 of byte 97.
//  - [SNN_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=100] 10 bytes then 100 idle cycles -> timeout_err pulses once.
//    98 further bytes -> start; no timeout_err while byte_cnt==0.

Source files
------------

// File: rtl/snn_input_loader.sv
// snn_input_loader
//   Feeds the SNN core from the UART receiver. It collects a NUM_PIXELS-bit binary image,
//   arriving as bytes with the LSB first, into an internal bit buffer. It then pulses start,
//   serves the core's pixel reads during inference, and captures the core's digit/done result.
//
// Ports
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   rx_rdy, rx_data[7:0]        byte strobe/data from uart_rx; bit i = pixel 8*k+i of byte k
//   addr_input_unit[9:0]        core pixel read address
//   q_input                     registered pixel read (1-cycle latency, 0 when out of range)
//   start                       one-cycle pulse: image complete
//   core_done, core_digit[3:0]  inference finished / result from the core
//   busy                        high from start until core_done is accepted
//   result_vld, result_digit    result update pulse / last classified digit
//   ovf_err                     sticky: byte arrived while busy (cleared by rst only)
//   timeout_err                 pulse: partial image discarded after inter-byte idle limit
//
// Optional feature: define SNN_LOAD_TIMEOUT_EN to enable the inter-byte idle timeout.
// When it is undefined, timeout_err is tied low and a partial image waits indefinitely.

module snn_input_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] addr_input_unit,
    output logic       q_input,
    output logic       start,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    output logic       busy,
    output logic       result_vld,
    output logic [3:0] result_digit,
    output logic       ovf_err,
    output logic       timeout_err
);

    localparam int         NUM_BYTES = NUM_PIXELS / 8;
    localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT_DONE} state_t;

    state_t                state_q, state_d;
    logic [6:0]            byte_cnt_q, byte_cnt_d;
    logic [NUM_PIXELS-1:0] buf_q;
    logic                  wr_en;
    logic [6:0]            wr_idx;
    logic                  q_input_q;
    logic                  result_vld_q, result_vld_d;
    logic [3:0]            result_digit_q, result_digit_d;
    logic                  ovf_err_q, ovf_err_d;
    logic                  timeout_hit;

`ifdef SNN_LOAD_TIMEOUT_EN
    localparam logic [18:0] IDLE_LAST = 19'(TIMEOUT_CYCLES - 1);

    logic [18:0] idle_q, idle_d;
    logic        timeout_err_q;

    // Idle counter only runs while a partial image is pending.
    always_comb begin
        idle_d      = '0;
        timeout_hit = 1'b0;
        if (state_q == S_LOAD && byte_cnt_q != '0) begin
            if (idle_q == IDLE_LAST)
                timeout_hit = 1'b1;
            else if (!rx_rdy)
                idle_d = idle_q + 19'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            timeout_err_q <= timeout_hit;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Next-state logic. On a timeout, a byte arriving in the same cycle
    // becomes byte 0 of a fresh image.
    always_comb begin
        state_d        = state_q;
        wr_idx         = timeout_hit ? 7'd0 : byte_cnt_q;
        byte_cnt_d     = wr_idx;
        wr_en          = 1'b0;
        result_vld_d   = 1'b0;
        result_digit_d = result_digit_q;
        ovf_err_d      = ovf_err_q;
        case (state_q)
            S_LOAD: begin
                if (rx_rdy) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = S_START;
                    end else begin
                        byte_cnt_d = wr_idx + 7'd1;
                    end
                end
            end
            S_START: begin
                // The core is already committed to this image; treat late bytes as overflow.
                if (rx_rdy) ovf_err_d = 1'b1;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (rx_rdy) ovf_err_d = 1'b1;
                if (core_done) begin
                    result_digit_d = core_digit;
                    result_vld_d   = 1'b1;
                    state_d        = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_LOAD;
            byte_cnt_q     <= '0;
            q_input_q      <= 1'b0;
            result_vld_q   <= 1'b0;
            result_digit_q <= '0;
            ovf_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            q_input_q      <= (int'(addr_input_unit) < NUM_PIXELS) ? buf_q[addr_input_unit] : 1'b0;
            result_vld_q   <= result_vld_d;
            result_digit_q <= result_digit_d;
            ovf_err_q      <= ovf_err_d;
        end
    end

    // Image storage is deliberately not reset; a new image overwrites it byte by byte.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[{wr_idx, 3'b000} +: 8] <= rx_data;
    end

    assign q_input      = q_input_q;
    assign start        = (state_q == S_START);
    assign busy         = (state_q != S_LOAD);
    assign result_vld   = result_vld_q;
    assign result_digit = result_digit_q;
    assign ovf_err      = ovf_err_q;

endmodule
